bus_ctrl: RTL and testbench

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/bus_pkg.sv | 30 +++
 rtl/spi_sync.sv | 29 ++
 rtl/bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_bus_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and types for the SPI-to-peripheral bus bridge.
// Holds the FSM encoding, default peripheral addresses and frame geometry.
package bus_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CMD       = 3'd1;
   localparam logic [2:0] ST_RD_STROBE = 3'd2;
   localparam logic [2:0] ST_DATA      = 3'd3;
   localparam logic [2:0] ST_WR_STROBE = 3'd4;

   localparam logic [6:0] DEF_SW_ADDR  = 7'h01;
   localparam logic [6:0] DEF_LED_ADDR = 7'h02;

   localparam int         FRAME_BITS   = 16;
   localparam int         BYTE_BITS    = FRAME_BITS / 2;
   localparam logic [2:0] LAST_BIT     = 3'(BYTE_BITS - 1);

   // Strobe sequencing: read strobe is 2 cycles, write strobe is 3 with ce in the middle.
   localparam logic [1:0] RD_STROBE_LAST = 2'd1;
   localparam logic [1:0] WR_STROBE_LAST = 2'd2;
   localparam logic [1:0] WR_CE_SLOT     = 2'd1;

   localparam logic [7:0] UNMAPPED_DATA  = 8'hFF;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
   } cmd_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection of the synchronized level in the clk domain.
module spi_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] meta_q;
   logic       prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         meta_q <= {meta_q[0], async_i};
         prev_q <= meta_q[1];
      end
   end

   assign sync_o = meta_q[1];
   assign rise_o = meta_q[1] & ~prev_q;
   assign fall_o = ~meta_q[1] & prev_q;

endmodule

// File: rtl/bus_ctrl.sv
// SPI-slave to parallel peripheral bus bridge: a 16-bit frame {rw, addr, data}
// becomes a read or write strobe on the shared bus_data lines.
module bus_ctrl
   import bus_pkg::*;
#(
   parameter logic [6:0] SW_ADDR  = DEF_SW_ADDR,
   parameter logic [6:0] LED_ADDR = DEF_LED_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   inout  wire  [8:1] bus_data,
   output logic       bus_rw,
   output logic       switches_ce,
   output logic       leds_ce
);

   logic sck_sync, sck_rise, sck_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic mosi_sync, mosi_rise, mosi_fall;

   spi_sync u_sync_sck (.clk(clk), .reset(reset), .async_i(sck),
                        .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall));
   spi_sync u_sync_ss (.clk(clk), .reset(reset), .async_i(ss_n),
                       .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall));
   spi_sync u_sync_mosi (.clk(clk), .reset(reset), .async_i(mosi),
                         .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall));

   logic unused_sync;
   assign unused_sync = ^{sck_sync, ss_rise, mosi_rise, mosi_fall};

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [1:0] strb_cnt_q, strb_cnt_d;
   cmd_t       cmd_q, cmd_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       miso_q, miso_d;
   logic       done_q, done_d;

   logic sw_hit, led_hit, ce_win, bus_oe;

   // SW wins if both addresses are configured equal, so the two ces stay exclusive.
   assign sw_hit  = (cmd_q.addr == SW_ADDR);
   assign led_hit = (cmd_q.addr == LED_ADDR) && !sw_hit;
   assign bus_oe  = (state_q == ST_WR_STROBE);
   assign ce_win  = (state_q == ST_RD_STROBE) ||
                    (bus_oe && strb_cnt_q == WR_CE_SLOT);

   assign switches_ce = ce_win & sw_hit;
   assign leds_ce     = ce_win & led_hit;
   assign bus_rw      = ~bus_oe;
   assign bus_data    = bus_oe ? rx_q : 8'hzz;
   assign miso        = miso_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      strb_cnt_d = strb_cnt_q;
      cmd_d      = cmd_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      miso_d     = miso_q;
      done_d     = done_q;
      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
               rx_d      = 8'h00;
               tx_d      = 8'h00;
               done_d    = 1'b0;
            end
         end
         ST_CMD: begin
            if (ss_sync) begin
               state_d = ST_IDLE;
            end else begin
               if (sck_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (sck_rise) begin
                  rx_d      = {rx_q[6:0], mosi_sync};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == LAST_BIT) begin
                     cmd_d      = cmd_t'({rx_q[6:0], mosi_sync});
                     strb_cnt_d = 2'd0;
                     state_d    = rx_q[6] ? ST_RD_STROBE : ST_DATA;
                  end
               end
            end
         end
         ST_RD_STROBE: begin
            strb_cnt_d = strb_cnt_q + 2'd1;
            if (strb_cnt_q == RD_STROBE_LAST) begin
               tx_d    = (sw_hit || led_hit) ? bus_data : UNMAPPED_DATA;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (ss_sync) begin
               state_d = ST_IDLE;
            end else if (!done_q) begin
               if (sck_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (sck_rise) begin
                  rx_d      = {rx_q[6:0], mosi_sync};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  // After byte 2 a read parks here until ss_n rises; a write strobes.
                  if (bit_cnt_q == LAST_BIT) begin
                     if (cmd_q.rw) begin
                        done_d = 1'b1;
                     end else begin
                        strb_cnt_d = 2'd0;
                        state_d    = ST_WR_STROBE;
                     end
                  end
               end
            end
         end
         ST_WR_STROBE: begin
            strb_cnt_d = strb_cnt_q + 2'd1;
            if (strb_cnt_q == WR_STROBE_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         strb_cnt_q <= 2'd0;
         cmd_q      <= '0;
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         miso_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         strb_cnt_q <= strb_cnt_d;
         cmd_q      <= cmd_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: SPI master bit-bang at clk = 8 x sck,
// a switches bus model returning 8'h3C, and ce/bus activity counters.
module tb_bus_ctrl;
   import bus_pkg::*;

   localparam int HALF = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sck = 1'b0;
   logic ss_n = 1'b1;
   logic mosi = 1'b0;
   logic miso, bus_rw, switches_ce, leds_ce;
   wire [8:1] bus_data;

   int checks = 0;
   int errors = 0;

   int sw_tot = 0, swrd_tot = 0, led_tot = 0, both_tot = 0;
   int wdrv_tot = 0, wrun = 0, ce_pos = 0;
   logic [7:0] led_data = 8'h00;
   logic       led_rw = 1'b1;

   always #5 clk = ~clk;

   assign bus_data = (switches_ce && bus_rw) ? 8'h3C : 8'hzz;

   bus_ctrl dut (
      .clk(clk), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
      .bus_data(bus_data), .bus_rw(bus_rw), .switches_ce(switches_ce), .leds_ce(leds_ce)
   );

   always @(negedge clk) begin
      if (switches_ce) sw_tot <= sw_tot + 1;
      if (switches_ce && bus_rw) swrd_tot <= swrd_tot + 1;
      if (leds_ce) begin
         led_tot  <= led_tot + 1;
         led_data <= bus_data;
         led_rw   <= bus_rw;
      end
      if (switches_ce && leds_ce) both_tot <= both_tot + 1;
      if (dut.bus_oe) begin
         wdrv_tot <= wdrv_tot + 1;
         wrun     <= wrun + 1;
         if (leds_ce || switches_ce) ce_pos <= wrun + 1;
      end else begin
         wrun <= 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mode 0 master: mosi changes with sck low, miso sampled just before sck rises.
   task automatic spi_xfer(input logic [15:0] txw, input int nbits, output logic [15:0] rxw);
      rxw = 16'h0000;
      ss_n = 1'b0;
      cyc(HALF);
      for (int i = 0; i < nbits; i++) begin
         mosi = txw[15-i];
         cyc(HALF);
         rxw[15-i] = miso;
         sck = 1'b1;
         cyc(HALF);
         sck = 1'b0;
      end
      mosi = 1'b0;
      cyc(HALF);
      ss_n = 1'b1;
      cyc(2*HALF);
   endtask

   task automatic test_reset();
      cyc(3);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
      checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL reset_bus_rw: got %b want 1", bus_rw); end
      checks++; if (switches_ce !== 1'b0) begin errors++; $display("FAIL reset_sw_ce: got %b want 0", switches_ce); end
      checks++; if (leds_ce !== 1'b0) begin errors++; $display("FAIL reset_led_ce: got %b want 0", leds_ce); end
      checks++; if (dut.bus_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_oe: got %b want 0", dut.bus_oe); end
      checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
      reset = 1'b0;
      cyc(4);
   endtask

   task automatic test_write_led();
      logic [15:0] r;
      int s_led, s_sw, s_wd;
      s_led = led_tot; s_sw = sw_tot; s_wd = wdrv_tot;
      spi_xfer({8'h02, 8'hA5}, 16, r);
      cyc(2);
      checks++; if (led_tot - s_led !== 1) begin errors++; $display("FAIL wr_led_ce_cycles: got %0d want 1", led_tot - s_led); end
      checks++; if (sw_tot - s_sw !== 0) begin errors++; $display("FAIL wr_sw_ce_cycles: got %0d want 0", sw_tot - s_sw); end
      checks++; if (wdrv_tot - s_wd !== 3) begin errors++; $display("FAIL wr_drive_cycles: got %0d want 3", wdrv_tot - s_wd); end
      checks++; if (ce_pos !== 2) begin errors++; $display("FAIL wr_ce_position: got %0d want 2", ce_pos); end
      checks++; if (led_data !== 8'hA5) begin errors++; $display("FAIL wr_bus_data: got %h want a5", led_data); end
      checks++; if (led_rw !== 1'b0) begin errors++; $display("FAIL wr_bus_rw: got %b want 0", led_rw); end
      checks++; if (r[15:8] !== 8'h00) begin errors++; $display("FAIL wr_miso_byte1: got %h want 00", r[15:8]); end
   endtask

   task automatic test_read_sw();
      logic [15:0] r;
      int s_sw, s_rd, s_led;
      s_sw = sw_tot; s_rd = swrd_tot; s_led = led_tot;
      spi_xfer({8'h81, 8'h00}, 16, r);
      cyc(2);
      checks++; if (r[15:8] !== 8'h00) begin errors++; $display("FAIL rd_miso_byte1: got %h want 00", r[15:8]); end
      checks++; if (r[7:0] !== 8'h3C) begin errors++; $display("FAIL rd_miso_byte2: got %h want 3c", r[7:0]); end
      checks++; if (sw_tot - s_sw !== 2) begin errors++; $display("FAIL rd_sw_ce_cycles: got %0d want 2", sw_tot - s_sw); end
      checks++; if (swrd_tot - s_rd !== 2) begin errors++; $display("FAIL rd_sw_ce_with_rw: got %0d want 2", swrd_tot - s_rd); end
      checks++; if (led_tot - s_led !== 0) begin errors++; $display("FAIL rd_led_ce_cycles: got %0d want 0", led_tot - s_led); end
   endtask

   task automatic test_read_unmapped();
      logic [15:0] r;
      int s_sw, s_led;
      s_sw = sw_tot; s_led = led_tot;
      spi_xfer({8'hFF, 8'h00}, 16, r);
      cyc(2);
      checks++; if (r[7:0] !== 8'hFF) begin errors++; $display("FAIL unm_miso_byte2: got %h want ff", r[7:0]); end
      checks++; if (r[15:8] !== 8'h00) begin errors++; $display("FAIL unm_miso_byte1: got %h want 00", r[15:8]); end
      checks++; if (sw_tot - s_sw !== 0) begin errors++; $display("FAIL unm_sw_ce_cycles: got %0d want 0", sw_tot - s_sw); end
      checks++; if (led_tot - s_led !== 0) begin errors++; $display("FAIL unm_led_ce_cycles: got %0d want 0", led_tot - s_led); end
   endtask

   task automatic test_abort();
      logic [15:0] r;
      int s_led, s_wd;
      s_led = led_tot; s_wd = wdrv_tot;
      spi_xfer({8'h02, 8'h77}, 12, r);
      cyc(2);
      checks++; if (led_tot - s_led !== 0) begin errors++; $display("FAIL abort_led_ce_cycles: got %0d want 0", led_tot - s_led); end
      checks++; if (wdrv_tot - s_wd !== 0) begin errors++; $display("FAIL abort_drive_cycles: got %0d want 0", wdrv_tot - s_wd); end
      checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dut.state_q, ST_IDLE); end
      s_led = led_tot;
      spi_xfer({8'h02, 8'h5A}, 16, r);
      cyc(2);
      checks++; if (led_tot - s_led !== 1) begin errors++; $display("FAIL abort_next_led_ce: got %0d want 1", led_tot - s_led); end
      checks++; if (led_data !== 8'h5A) begin errors++; $display("FAIL abort_next_data: got %h want 5a", led_data); end
   endtask

   task automatic test_reset_mid_strobe();
      logic [15:0] r;
      fork
         spi_xfer({8'h02, 8'hC3}, 16, r);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!leds_ce && n < 400) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if (!leds_ce) begin
               errors++;
               $display("FAIL rst_strobe_wait: got no leds_ce want leds_ce within 400 cycles");
            end
            #1 reset = 1'b1;
            #1;
            checks++; if (leds_ce !== 1'b0) begin errors++; $display("FAIL rst_strobe_led_ce: got %b want 0", leds_ce); end
            checks++; if (switches_ce !== 1'b0) begin errors++; $display("FAIL rst_strobe_sw_ce: got %b want 0", switches_ce); end
            checks++; if (dut.bus_oe !== 1'b0) begin errors++; $display("FAIL rst_strobe_bus_oe: got %b want 0", dut.bus_oe); end
            checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL rst_strobe_bus_rw: got %b want 1", bus_rw); end
            checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_strobe_miso: got %b want 0", miso); end
         end
      join
      cyc(2);
      reset = 1'b0;
      cyc(4);
   endtask

   task automatic test_back_to_back();
      logic [15:0] r1, r2;
      int s_led, s_sw;
      s_led = led_tot; s_sw = sw_tot;
      spi_xfer({8'h02, 8'h96}, 16, r1);
      spi_xfer({8'h81, 8'h00}, 16, r2);
      cyc(2);
      checks++; if (led_tot - s_led !== 1) begin errors++; $display("FAIL b2b_led_ce_cycles: got %0d want 1", led_tot - s_led); end
      checks++; if (led_data !== 8'h96) begin errors++; $display("FAIL b2b_write_data: got %h want 96", led_data); end
      checks++; if (sw_tot - s_sw !== 2) begin errors++; $display("FAIL b2b_sw_ce_cycles: got %0d want 2", sw_tot - s_sw); end
      checks++; if (r2[7:0] !== 8'h3C) begin errors++; $display("FAIL b2b_read_data: got %h want 3c", r2[7:0]); end
   endtask

   initial begin
      test_reset();
      test_write_led();
      test_read_sw();
      test_read_unmapped();
      test_abort();
      test_reset_mid_strobe();
      test_back_to_back();
      checks++; if (both_tot !== 0) begin errors++; $display("FAIL ce_exclusive: got %0d overlap cycles want 0", both_tot); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit reached want completion");
      $fatal(1, "watchdog");
   end

endmodule
